// File: rtl/dmem_line_memory_if.sv
// Request/response bundle between the data cache (master) and the line memory (slave).
interface dmem_line_memory_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LINE_W = 128
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_wdata;
  logic              resp_valid;
  logic [LINE_W-1:0] resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dmem_line_memory.sv
// Fixed-latency, one-request-at-a-time line memory below the data cache.
// Optional macro DMEM_OOR_ERR_EN: out-of-range line addresses raise resp_err instead of wrapping.
module dmem_line_memory #(
  parameter int unsigned LINE_W      = 128,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned MEM_LATENCY = 5
) (
  input  logic               clock,
  input  logic               reset,
  dmem_line_memory_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  logic [LINE_W-1:0] memArray [DEPTH];

  logic              accept_c;
  logic              commit_c;
  logic              cmt_write_c;
  logic [ADDR_W-1:0] cmt_addr_c;
  logic [LINE_W-1:0] cmt_wdata_c;
  logic [IDX_W-1:0]  idx_c;
  logic              oor_c;
  logic              wr_en_c;
  logic [LINE_W-1:0] rd_data_c;

  assign accept_c = (state == IDLE) && bus.req_valid && bus.req_ready;

  // With unit latency the accept edge is also the commit edge, so live inputs are used.
  assign commit_c    = (accept_c && (MEM_LATENCY == 1)) || ((state == WAIT) && (cnt == CNT_W'(1)));
  assign cmt_write_c = (state == IDLE) ? bus.req_write : lat_write;
  assign cmt_addr_c  = (state == IDLE) ? bus.req_addr  : lat_addr;
  assign cmt_wdata_c = (state == IDLE) ? bus.req_wdata : lat_wdata;
  assign idx_c       = cmt_addr_c[IDX_W-1:0];

`ifdef DMEM_OOR_ERR_EN
  assign oor_c     = (cmt_addr_c >= ADDR_W'(DEPTH));
  assign rd_data_c = oor_c ? '0 : (cmt_write_c ? cmt_wdata_c : memArray[idx_c]);
`else
  logic unused_addr_c;
  assign unused_addr_c = ^cmt_addr_c[ADDR_W-1:IDX_W];
  assign oor_c         = 1'b0;
  assign rd_data_c     = cmt_write_c ? cmt_wdata_c : memArray[idx_c];
  assign bus.resp_err  = 1'b0;
`endif

  assign wr_en_c = commit_c && cmt_write_c && !oor_c;

  // Storage is never reset; a reset coinciding with the commit edge suppresses the write.
  always_ff @(posedge clock) begin
    if (wr_en_c && !reset) begin
      memArray[idx_c] <= cmt_wdata_c;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      lat_write      <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.busy       <= 1'b0;
`ifdef DMEM_OOR_ERR_EN
      bus.resp_err   <= 1'b0;
`endif
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            lat_write     <= bus.req_write;
            lat_addr      <= bus.req_addr;
            lat_wdata     <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            bus.busy      <= 1'b1;
            if (MEM_LATENCY == 1) begin
              state <= RESP;
            end else begin
              cnt   <= CNT_W'(MEM_LATENCY - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= RESP;
          end
        end
        RESP: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
      endcase

      // Response payload is captured only on the edge entering RESP.
      if (commit_c) begin
        bus.resp_valid <= 1'b1;
        bus.resp_rdata <= rd_data_c;
`ifdef DMEM_OOR_ERR_EN
        bus.resp_err   <= oor_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_dmem_line_memory.sv
// Randomized bench for dmem_line_memory: two instances (latency 5 and latency 1) against a line-array model.
module tb_dmem_line_memory;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_line_memory_if #(.ADDR_W(12), .LINE_W(128)) bus5 ();
  dmem_line_memory_if #(.ADDR_W(12), .LINE_W(128)) bus1 ();

  dmem_line_memory #(.LINE_W(128), .DEPTH(1024), .ADDR_W(12), .MEM_LATENCY(5)) dut5 (
    .clock(clock), .reset(reset), .bus(bus5));
  dmem_line_memory #(.LINE_W(128), .DEPTH(1024), .ADDR_W(12), .MEM_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1));

  int tests = 0;
  int fails = 0;
  logic [127:0] model [2][16];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic f_ready(input int sel);
    return (sel == 1) ? bus1.req_ready : bus5.req_ready;
  endfunction
  function automatic logic f_rv(input int sel);
    return (sel == 1) ? bus1.resp_valid : bus5.resp_valid;
  endfunction
  function automatic logic [127:0] f_rd(input int sel);
    return (sel == 1) ? bus1.resp_rdata : bus5.resp_rdata;
  endfunction
  function automatic logic f_err(input int sel);
    return (sel == 1) ? bus1.resp_err : bus5.resp_err;
  endfunction
  function automatic logic f_busy(input int sel);
    return (sel == 1) ? bus1.busy : bus5.busy;
  endfunction
  function automatic logic [127:0] f_mem(input int sel, input int idx);
    return (sel == 1) ? dut1.memArray[idx] : dut5.memArray[idx];
  endfunction

  task automatic drive(input int sel, input logic v, input logic w, input logic [11:0] a,
                       input logic [127:0] d);
    if (sel == 1) begin
      bus1.req_valid = v; bus1.req_write = w; bus1.req_addr = a; bus1.req_wdata = d;
    end else begin
      bus5.req_valid = v; bus5.req_write = w; bus5.req_addr = a; bus5.req_wdata = d;
    end
  endtask

  // Expected result comes from the model: wrap modulo 1024, or flag out-of-range when enabled.
  task automatic rtxn(input int sel, input logic w, input logic [11:0] a, input logic [127:0] d);
    int           lat;
    int           k;
    int           s;
    int           idx;
    logic         oor;
    logic [127:0] exp_rd;
    logic         chk_rd;
    lat = (sel == 1) ? 1 : 5;
    s   = (sel == 1) ? 1 : 0;
    idx = int'(a) % 1024;
`ifdef DMEM_OOR_ERR_EN
    oor = (int'(a) >= 1024);
`else
    oor = 1'b0;
`endif
    if (w) begin
      exp_rd = d;
      chk_rd = !oor;
    end else begin
      exp_rd = oor ? 128'd0 : model[s][idx];
      chk_rd = 1'b1;
    end
    check($sformatf("ready_idle%0d", sel), 128'(f_ready(sel)), 128'd1);
    drive(sel, 1'b1, w, a, d);
    @(posedge clock); #1;
    drive(sel, 1'b0, 1'b0, 12'd0, 128'd0);
    k = 1;
    if (lat > 1) begin
      check($sformatf("busy_wait%0d", sel), 128'(f_busy(sel)), 128'd1);
      check($sformatf("ready_wait%0d", sel), 128'(f_ready(sel)), 128'd0);
    end
    while (!f_rv(sel) && k < 300) begin
      @(posedge clock); #1;
      k++;
    end
    check($sformatf("latency%0d a=%0h", sel, a), 128'(k), 128'(lat));
    if (chk_rd) check($sformatf("rdata%0d a=%0h", sel, a), f_rd(sel), exp_rd);
    check($sformatf("err%0d a=%0h", sel, a), 128'(f_err(sel)), 128'(oor));
    if (w && !oor) check($sformatf("mem_commit%0d a=%0h", sel, a), f_mem(sel, idx), d);
    @(posedge clock); #1;
    check($sformatf("pulse_end%0d", sel), 128'(f_rv(sel)), 128'd0);
    if (chk_rd) check($sformatf("rdata_hold%0d", sel), f_rd(sel), exp_rd);
    if (w && !oor) model[s][idx] = d;
  endtask

  // Holds req_valid high for n reads and checks acceptance spacing and in-order responses.
  task automatic stream(input int sel, input int n, input int base);
    int           acc_cyc [$];
    logic [127:0] expq [$];
    int           accepts;
    int           resps;
    int           s;
    int           lat;
    s = (sel == 1) ? 1 : 0;
    lat = (sel == 1) ? 1 : 5;
    accepts = 0;
    resps = 0;
    for (int c = 0; c < 40; c++) begin
      if (accepts < n) drive(sel, 1'b1, 1'b0, 12'(base + accepts), 128'd0);
      else drive(sel, 1'b0, 1'b0, 12'd0, 128'd0);
      if (f_ready(sel) && accepts < n) begin
        acc_cyc.push_back(c);
        expq.push_back(model[s][base + accepts]);
        accepts++;
      end
      @(posedge clock); #1;
      if (f_rv(sel)) begin
        check($sformatf("stream_extra%0d", sel), 128'(expq.size() > 0), 128'd1);
        if (expq.size() > 0) check($sformatf("stream_data%0d", sel), f_rd(sel), expq.pop_front());
        resps++;
      end
    end
    drive(sel, 1'b0, 1'b0, 12'd0, 128'd0);
    check($sformatf("stream_accepts%0d", sel), 128'(accepts), 128'(n));
    check($sformatf("stream_resps%0d", sel), 128'(resps), 128'(n));
    for (int i = 1; i < acc_cyc.size(); i++)
      check($sformatf("stream_gap%0d_%0d", sel, i), 128'(acc_cyc[i] - acc_cyc[i-1]), 128'(lat + 1));
  endtask

  initial begin
    logic [127:0] d;
    logic [11:0]  a;
    int           k;
    drive(5, 1'b0, 1'b0, 12'd0, 128'd0);
    drive(1, 1'b0, 1'b0, 12'd0, 128'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_ready", 128'(bus5.req_ready), 128'd1);
    check("rst_rv", 128'(bus5.resp_valid), 128'd0);
    check("rst_rdata", bus5.resp_rdata, 128'd0);
    check("rst_err", 128'(bus5.resp_err), 128'd0);
    check("rst_busy", 128'(bus5.busy), 128'd0);
    @(posedge clock); #1;

    // Fill lines 0..15 on both instances so every later read has a known value.
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      if (i == 0) d = {32'd4, 32'd3, 32'd2, 32'd1};
      if (i == 7) d = 128'h55;
      rtxn(5, 1'b1, 12'(i), d);
      rtxn(1, 1'b1, 12'(i), {$urandom, $urandom, $urandom, $urandom});
    end

    rtxn(5, 1'b0, 12'd0, 128'd0);
    rtxn(5, 1'b1, 12'd3, 128'hDEADBEEF);
    rtxn(5, 1'b0, 12'd3, 128'd0);
    check("raw_line3", dut5.memArray[3], 128'hDEADBEEF);

    stream(5, 4, 8);
    stream(1, 3, 4);

    // Reset two cycles into a write: the line must keep its old value.
    drive(5, 1'b1, 1'b1, 12'd7, 128'hABCD);
    @(posedge clock); #1;
    drive(5, 1'b0, 1'b0, 12'd0, 128'd0);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check("arst_ready", 128'(bus5.req_ready), 128'd1);
    check("arst_busy", 128'(bus5.busy), 128'd0);
    check("arst_rv", 128'(bus5.resp_valid), 128'd0);
    check("arst_rdata", bus5.resp_rdata, 128'd0);
    check("arst_err", 128'(bus5.resp_err), 128'd0);
    @(posedge clock); #3;
    reset = 1'b0;
    @(posedge clock); #1;
    check("arst_line7", dut5.memArray[7], 128'h55);
    rtxn(5, 1'b0, 12'd7, 128'd0);

    // Reset while the response pulse is up drops it at once.
    drive(5, 1'b1, 1'b0, 12'd7, 128'd0);
    @(posedge clock); #1;
    drive(5, 1'b0, 1'b0, 12'd0, 128'd0);
    k = 0;
    while (!bus5.resp_valid && k < 300) begin
      @(posedge clock); #1;
      k++;
    end
    check("pulse_seen", 128'(bus5.resp_valid), 128'd1);
    #2 reset = 1'b1;
    #1 check("arst_pulse_drop", 128'(bus5.resp_valid), 128'd0);
    @(posedge clock); #3;
    reset = 1'b0;
    @(posedge clock); #1;

    rtxn(1, 1'b0, 12'd1, 128'd0);
    rtxn(5, 1'b0, 12'd1025, 128'd0);
    rtxn(5, 1'b1, 12'd1026, 128'h1234_5678);
    rtxn(5, 1'b0, 12'd2, 128'd0);

    for (int i = 0; i < 40; i++) begin
      a = 12'($urandom_range(0, 15)) + (($urandom_range(0, 3) == 0) ? 12'd1024 : 12'd0);
      rtxn(5, 1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom});
    end
    for (int i = 0; i < 30; i++) begin
      a = 12'($urandom_range(0, 15)) + (($urandom_range(0, 3) == 0) ? 12'd1024 : 12'd0);
      rtxn(1, 1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
